wallace_pipe_mult: RTL and testbench

Parametrised, pipelined Wallace-tree multiplier with a per-transaction signed/unsigned mode and valid/ready handshakes on both sides. It is the sequential successor to the team's 4x4 combinational Wallace multiplier. It sits between operand producers (register file, DSP datapath) and consumers that may stall. It sustains one product per clock with a fixed 3-cycle latency.

---
 rtl/wallace_pipe_mult.sv | 172 +++++++++++++++++
 tb/tb_wallace_pipe_mult.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_pipe_mult.sv
// Pipelined N x N Wallace-tree multiplier with per-transaction signed or
// unsigned mode and valid/ready handshakes on both sides.
// Stage 1 captures the operands. Stage 2 builds Baugh-Wooley or plain partial
// products and reduces them to two rows with a carry-save tree. Stage 3 adds
// the two rows into prod. A single global advance signal stalls all stages.
module wallace_pipe_mult #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           sgn,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] prod
);

   localparam int W      = 2 * N;
   localparam int R      = N + 1;   // N partial-product rows plus one correction row
   localparam int LEVELS = 8;       // enough 3:2 levels to reduce 17 rows to 2

   // carry-save sum of three rows
   function automatic logic [W-1:0] csa_sum(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] z);
      return x ^ y ^ z;
   endfunction

   // carry-save carry of three rows, already shifted to its weight
   function automatic logic [W-1:0] csa_carry(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic [W-1:0] z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   // Partial products plus Wallace reduction; returns {row1, row0}.
   // Signed mode inverts the cross terms that involve exactly one MSB and adds
   // the correction constant 2^N + 2^(2N-1) as an extra row.
   function automatic logic [2*W-1:0] wallace(input logic [N-1:0] a,
                                              input logic [N-1:0] b,
                                              input logic         s);
      logic [W-1:0] cur [R];
      logic [W-1:0] nxt [R];
      logic         bit_v;
      int           cnt;
      int           ncnt;
      int           base;
      for (int k = 0; k < R; k++) begin
         cur[k] = '0;
         nxt[k] = '0;
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            bit_v = a[j] & b[i];
            if (s && ((i == N - 1) != (j == N - 1))) begin
               bit_v = ~bit_v;
            end else begin
               bit_v = bit_v;
            end
            cur[i][i + j] = bit_v;
         end
      end
      cur[N][N]     = s;
      cur[N][W - 1] = s;
      cnt = R;
      for (int l = 0; l < LEVELS; l++) begin
         for (int k = 0; k < R; k++) begin
            nxt[k] = '0;
         end
         ncnt = 0;
         for (int g = 0; g < R; g++) begin
            base = 3 * g;
            if (base + 2 < cnt) begin
               nxt[ncnt]     = csa_sum(cur[base], cur[base + 1], cur[base + 2]);
               nxt[ncnt + 1] = csa_carry(cur[base], cur[base + 1], cur[base + 2]);
               ncnt = ncnt + 2;
            end else if (base < cnt) begin
               nxt[ncnt] = cur[base];
               ncnt = ncnt + 1;
               if (base + 1 < cnt) begin
                  nxt[ncnt] = cur[base + 1];
                  ncnt = ncnt + 1;
               end else begin
                  ncnt = ncnt;
               end
            end else begin
               ncnt = ncnt;
            end
         end
         for (int k = 0; k < R; k++) begin
            cur[k] = nxt[k];
         end
         cnt = ncnt;
      end
      return {cur[1], cur[0]};
   endfunction

   logic           adv_s;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic           sgn_r;
   logic           v1_r;
   logic [2*W-1:0] red_s;
   logic [W-1:0]   row0_r;
   logic [W-1:0]   row1_r;
   logic           v2_r;
   logic [W-1:0]   prod_r;
   logic           v3_r;

   assign adv_s     = !v3_r || out_ready;
   assign in_ready  = adv_s;
   assign out_valid = v3_r;
   assign prod      = prod_r;

   // reduce the captured operands to two carry-save rows
   always_comb begin
      red_s = wallace(a_r, b_r, sgn_r);
   end

   // stage 1: capture operands, mode and the input valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         sgn_r <= 1'b0;
         v1_r  <= 1'b0;
      end else if (adv_s) begin
         a_r   <= A;
         b_r   <= B;
         sgn_r <= sgn;
         v1_r  <= in_valid;
      end else begin
         v1_r  <= v1_r;
      end
   end

   // stage 2: register the two reduced rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row0_r <= '0;
         row1_r <= '0;
         v2_r   <= 1'b0;
      end else if (adv_s) begin
         row0_r <= red_s[W-1:0];
         row1_r <= red_s[2*W-1:W];
         v2_r   <= v1_r;
      end else begin
         v2_r   <= v2_r;
      end
   end

   // stage 3: final carry-propagate add; prod keeps the last valid result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_r <= '0;
         v3_r   <= 1'b0;
      end else if (adv_s) begin
         if (v2_r) begin
            prod_r <= row0_r + row1_r;
         end else begin
            prod_r <= prod_r;
         end
         v3_r <= v2_r;
      end else begin
         v3_r <= v3_r;
      end
   end

endmodule

// File: tb/tb_wallace_pipe_mult.sv
// Self-checking bench for wallace_pipe_mult: an N=4 instance for exhaustive
// sweeps and an N=8 instance for corners, backpressure, random throttling and
// mid-flight reset. Expected products are queued on each input transfer and
// popped on each output transfer.
module tb_wallace_pipe_mult;

   logic clk = 1'b0;
   logic rst_n;

   logic        v4, s4, or4, ir4, ov4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        v8, s8, or8, ir8, ov8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int acc8   = 0;
   int out8   = 0;

   logic [7:0]  q4 [$];
   logic [7:0]  got4 [$];
   logic [15:0] q8 [$];
   int          t8 [$];
   logic [15:0] got8 [$];

   wallace_pipe_mult #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .A(a4), .B(b4),
      .sgn(s4), .out_valid(ov4), .out_ready(or4), .prod(p4));

   wallace_pipe_mult #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .A(a8), .B(b8),
      .sgn(s8), .out_valid(ov8), .out_ready(or8), .prod(p8));

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] m4(input logic [3:0] a, input logic [3:0] b, input logic s);
      logic signed [7:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (s) return sa * sb;
      else   return {4'd0, a} * {4'd0, b};
   endfunction

   function automatic logic [15:0] m8(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic signed [15:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (s) return sa * sb;
      else   return {8'd0, a} * {8'd0, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (v4 && ir4) q4.push_back(m4(a4, b4, s4));
         if (ov4 && or4) begin
            if (q4.size() == 0) begin
               n_chk++;
               $error("FAIL stale4: observed %0h expected no output", p4);
            end else begin
               chk("prod4", p4, q4.pop_front());
               got4.push_back(p4);
            end
         end
         if (v8 && ir8) begin
            q8.push_back(m8(a8, b8, s8));
            t8.push_back(cyc);
            acc8++;
         end
         if (ov8 && or8) begin
            if (q8.size() == 0) begin
               n_chk++;
               $error("FAIL stale8: observed %0h expected no output", p8);
            end else begin
               chk("prod8", p8, q8.pop_front());
               chk("lat8_min3", (cyc - t8.pop_front()) >= 3, 1);
               got8.push_back(p8);
               out8++;
            end
         end
      end
   end

   logic [15:0] corner_exp [6];
   logic [23:0] corner_in  [6];
   logic [15:0] snap;
   int          base_acc, base_out, n_wait;
   logic        acc_seen;

   initial begin
      rst_n = 1'b0;
      v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
      v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
      corner_in[0] = {8'hFF, 8'hFF, 8'h00}; corner_exp[0] = 16'hFE01;
      corner_in[1] = {8'h80, 8'h80, 8'h01}; corner_exp[1] = 16'h4000;
      corner_in[2] = {8'h00, 8'h5A, 8'h00}; corner_exp[2] = 16'h0000;
      corner_in[3] = {8'h80, 8'h7F, 8'h01}; corner_exp[3] = 16'hC080;
      corner_in[4] = {8'h12, 8'h34, 8'h00}; corner_exp[4] = 16'h03A8;
      corner_in[5] = {8'hFF, 8'hFF, 8'h01}; corner_exp[5] = 16'h0001;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov8", ov8, 0);
      chk("rst_p8", p8, 0);
      chk("rst_p4", p4, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ir8", ir8, 1);
      chk("rst_ir4", ir4, 1);

      // exhaustive N=4, unsigned then signed, streamed back-to-back
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               @(posedge clk); #1;
               v4 = 1'b1; a4 = 4'(a); b4 = 4'(b); s4 = 1'(s);
            end
         end
      end
      @(posedge clk); #1;
      v4 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("cnt4", got4.size(), 512);
      chk("u4_15x15", got4[255], 8'hE1);
      chk("s4_8x8", got4[392], 8'h40);
      chk("s4_8x7", got4[391], 8'hC8);
      chk("s4_ffxff", got4[511], 8'h01);

      // N=8 corners, mode alternating every cycle
      got8.delete();
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         v8 = 1'b1; a8 = corner_in[k][23:16]; b8 = corner_in[k][15:8]; s8 = corner_in[k][0];
      end
      @(posedge clk); #1;
      v8 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("corner_cnt", got8.size(), 6);
      for (int k = 0; k < 6; k++) chk("corner_val", got8[k], corner_exp[k]);

      // backpressure: out_ready low for 5 cycles, in_valid held high
      base_acc = acc8;
      base_out = out8;
      or8 = 1'b0; v8 = 1'b1; a8 = 8'd10; b8 = 8'd20; s8 = 1'b0;
      snap = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         acc_seen = ir8;
         if (i == 3) snap = p8;
         @(posedge clk); #1;
         if (acc_seen) a8 = a8 + 8'd1;
      end
      @(negedge clk);
      chk("bp_accepted", acc8 - base_acc, 3);
      chk("bp_in_ready", ir8, 0);
      chk("bp_out_valid", ov8, 1);
      chk("bp_snap", snap, 16'd200);
      chk("bp_stable", p8, snap);
      @(posedge clk); #1;
      or8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("bp_outputs", out8 - base_out, 4);
      chk("bp_drained", q8.size(), 0);

      // random throttling, 1000 accepted transactions
      base_acc = acc8;
      n_wait = 0;
      while ((acc8 - base_acc) < 1000 && n_wait < 20000) begin
         @(negedge clk);
         acc_seen = v8 && ir8;
         @(posedge clk); #1;
         if (!v8 || acc_seen) begin
            v8 = 1'($urandom_range(1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom_range(1));
         end
         or8 = 1'($urandom_range(1));
         n_wait++;
      end
      v8 = 1'b0;
      or8 = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rand_accepted", acc8 - base_acc, 1000);
      chk("rand_drained", q8.size(), 0);

      // reset with three transactions in flight
      or8 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         v8 = 1'b1; a8 = 8'(k + 7); b8 = 8'd9; s8 = 1'b0;
      end
      @(posedge clk); #1;
      v8 = 1'b0;
      chk("mid_full", ov8, 1);
      #1;
      rst_n = 1'b0;
      q8.delete();
      t8.delete();
      #1;
      chk("mid_rst_ov8", ov8, 0);
      chk("mid_rst_p8", p8, 0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_ir8", ir8, 1);
      or8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b1; a8 = 8'd3; b8 = 8'd5; s8 = 1'b0;
      @(posedge clk); #1;
      v8 = 1'b0;
      n_wait = 0;
      do begin
         @(negedge clk);
         n_wait++;
      end while (!ov8 && n_wait < 20);
      chk("post_rst_lat", n_wait, 3);
      chk("post_rst_prod", p8, 16'h000F);
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_drained", q8.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
